// File: rtl/load_sched_pkg.sv
// Shared types and constants for the load command scheduler.
package load_sched_pkg;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 12;
  localparam int ID_W   = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ABORT = 2'd3
  } state_e;

  // One queued whole-tensor load descriptor
  typedef struct packed {
    logic [ADDR_W-1:0] dram_addr;
    logic [ADDR_W-1:0] ld_addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        str;
    logic [1:0]        sram_type;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

endpackage

// File: rtl/load_cmd_fifo.sv
// Synchronous descriptor FIFO with full/empty flags (DEPTH power of 2).
module load_cmd_fifo
  import load_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DESC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Pointer advance; the extra MSB distinguishes full from empty
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, not reset (contents only valid between pointers)
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/load_cmd_scheduler.sv
// Load command scheduler: queues tensor load descriptors, splits them into
// AXI read bursts, tracks R-channel completion and reports done/error.
// Optional macro LOAD_SCHED_RETRY_EN: re-issue errored bursts up to MAX_RETRY
// times before aborting; when undefined any bad burst aborts the descriptor.
module load_cmd_scheduler
  import load_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_BEATS = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_dram_addr,
  input  logic [ADDR_W-1:0] cmd_ld_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_str,
  input  logic [1:0]        cmd_sram_type,
  output logic              ctrl_load_vld,
  output logic [ID_W-1:0]   ctrl_load_id,
  output logic [ADDR_W-1:0] ctrl_load_dram_addr,
  output logic [7:0]        ctrl_load_len,
  output logic [2:0]        ctrl_load_size,
  output logic [2:0]        ctrl_load_str,
  output logic [ADDR_W-1:0] ctrl_load_ld_addr,
  output logic [1:0]        ctrl_load_sram_type,
  input  logic [ID_W-1:0]   ctrl_sram_rid,
  input  logic [1:0]        ctrl_sram_rresp,
  input  logic              ctrl_sram_rlast,
  input  logic              ctrl_sram_rvld,
  output logic              sched_busy,
  output logic              sched_done,
  output logic              sched_err
);

  // Reject parameter sets the datapath widths cannot represent
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BEATS < 1 || MAX_BEATS > 256 ||
      MAX_RETRY < 0) begin : g_bad_params
    $error("load_cmd_scheduler: illegal parameter set");
  end

  localparam logic [LEN_W-1:0] MAXB_LEN  = LEN_W'(MAX_BEATS);
  localparam logic [8:0]       MAXB_BEAT = 9'(MAX_BEATS);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [2:0]        str_q, str_d;
  logic [1:0]        type_q, type_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic              done_q, done_d;

`ifdef LOAD_SCHED_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  desc_t      push_desc, pop_desc;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [8:0] beats_c;
  logic [7:0] arlen_c;
  logic [LEN_W-1:0] rem_next;
  logic       beat_hit, beat_err, bad_now, issuing;

  assign cmd_rdy   = rst_n & ~fifo_full;
  assign fifo_push = cmd_vld & cmd_rdy;
  assign push_desc = '{dram_addr: cmd_dram_addr, ld_addr: cmd_ld_addr, len: cmd_len,
                       str: cmd_str, sram_type: cmd_sram_type};

  load_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(DESC_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_desc),
    .rdata (pop_desc),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Burst sizing and R-beat qualification
  always_comb begin
    beats_c  = (rem_q > MAXB_LEN) ? MAXB_BEAT : rem_q[8:0];
    arlen_c  = 8'(beats_c - 9'd1);
    rem_next = rem_q - {3'b000, beats_c};
    beat_hit = ctrl_sram_rvld && (ctrl_sram_rid == cur_id_q);
    beat_err = (ctrl_sram_rresp == RESP_SLVERR) || (ctrl_sram_rresp == RESP_DECERR);
    bad_now  = bad_q | beat_err;
  end

  // Next-state and working-register updates
  always_comb begin
    state_d  = state_q;
    id_cnt_d = id_cnt_q;
    cur_id_d = cur_id_q;
    rem_d    = rem_q;
    daddr_d  = daddr_q;
    saddr_d  = saddr_q;
    str_d    = str_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
`ifdef LOAD_SCHED_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rem_d    = pop_desc.len;
          daddr_d  = pop_desc.dram_addr;
          saddr_d  = pop_desc.ld_addr;
          str_d    = pop_desc.str;
          type_d   = pop_desc.sram_type;
`ifdef LOAD_SCHED_RETRY_EN
          retry_d  = '0;
`endif
          if (pop_desc.len == '0) done_d  = 1'b1;
          else                    state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cur_id_d = id_cnt_q;
        id_cnt_d = id_cnt_q + 8'd1;
        cnt_d    = '0;
        bad_d    = 1'b0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (beat_hit) begin
          cnt_d = cnt_q + 9'd1;
          bad_d = bad_now;
          if (ctrl_sram_rlast) begin
            if (!bad_now && (cnt_q + 9'd1 == beats_c)) begin
              daddr_d = daddr_q + {1'b0, beats_c, 2'b00};
              saddr_d = saddr_q + {3'b000, beats_c};
              rem_d   = rem_next;
              if (rem_next == '0) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_ISSUE;
              end
            end else begin
`ifdef LOAD_SCHED_RETRY_EN
              if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = S_ISSUE;
              end else begin
                state_d = S_ABORT;
              end
`else
              state_d = S_ABORT;
`endif
            end
          end
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, reset to idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_cnt_q <= '0;
      done_q   <= 1'b0;
`ifdef LOAD_SCHED_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      id_cnt_q <= id_cnt_d;
      done_q   <= done_d;
`ifdef LOAD_SCHED_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  // Working registers, loaded before use so left unreset
  always_ff @(posedge clk) begin
    cur_id_q <= cur_id_d;
    rem_q    <= rem_d;
    daddr_q  <= daddr_d;
    saddr_q  <= saddr_d;
    str_q    <= str_d;
    type_q   <= type_d;
    cnt_q    <= cnt_d;
    bad_q    <= bad_d;
  end

  // Command fields are only driven during the issue cycle so they read 0 otherwise
  always_comb begin
    issuing             = (state_q == S_ISSUE);
    ctrl_load_vld       = issuing;
    ctrl_load_id        = issuing ? id_cnt_q    : '0;
    ctrl_load_dram_addr = issuing ? daddr_q     : '0;
    ctrl_load_len       = issuing ? arlen_c     : '0;
    ctrl_load_size      = issuing ? AXI_SIZE_4B : '0;
    ctrl_load_str       = issuing ? str_q       : '0;
    ctrl_load_ld_addr   = issuing ? saddr_q     : '0;
    ctrl_load_sram_type = issuing ? type_q      : '0;
    sched_busy          = (state_q != S_IDLE) | ~fifo_empty;
    sched_done          = done_q;
    sched_err           = (state_q == S_ABORT);
  end

endmodule

// File: tb/tb_load_cmd_scheduler.sv
// Self-checking bench for load_cmd_scheduler (default and LOAD_SCHED_RETRY_EN builds).
module tb_load_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [11:0] cmd_dram_addr, cmd_ld_addr, cmd_len;
  logic [2:0]  cmd_str;
  logic [1:0]  cmd_sram_type;
  logic        ctrl_load_vld;
  logic [7:0]  ctrl_load_id;
  logic [11:0] ctrl_load_dram_addr;
  logic [7:0]  ctrl_load_len;
  logic [2:0]  ctrl_load_size, ctrl_load_str;
  logic [11:0] ctrl_load_ld_addr;
  logic [1:0]  ctrl_load_sram_type;
  logic [7:0]  ctrl_sram_rid;
  logic [1:0]  ctrl_sram_rresp;
  logic        ctrl_sram_rlast, ctrl_sram_rvld;
  logic        sched_busy, sched_done, sched_err;

  always #5 clk = ~clk;

  load_cmd_scheduler #(.DEPTH(4), .MAX_BEATS(16), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_dram_addr(cmd_dram_addr), .cmd_ld_addr(cmd_ld_addr), .cmd_len(cmd_len),
    .cmd_str(cmd_str), .cmd_sram_type(cmd_sram_type),
    .ctrl_load_vld(ctrl_load_vld), .ctrl_load_id(ctrl_load_id),
    .ctrl_load_dram_addr(ctrl_load_dram_addr), .ctrl_load_len(ctrl_load_len),
    .ctrl_load_size(ctrl_load_size), .ctrl_load_str(ctrl_load_str),
    .ctrl_load_ld_addr(ctrl_load_ld_addr), .ctrl_load_sram_type(ctrl_load_sram_type),
    .ctrl_sram_rid(ctrl_sram_rid), .ctrl_sram_rresp(ctrl_sram_rresp),
    .ctrl_sram_rlast(ctrl_sram_rlast), .ctrl_sram_rvld(ctrl_sram_rvld),
    .sched_busy(sched_busy), .sched_done(sched_done), .sched_err(sched_err)
  );

  typedef struct {
    logic [11:0] len, da, sa;
    logic [2:0]  st;
    logic [1:0]  ty;
    int          nb;
  } desc_vec_t;

  typedef struct {
    logic [11:0] da, sa;
    logic [7:0]  al;
  } burst_vec_t;

  desc_vec_t  dv[4];
  burst_vec_t bv[7];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_id = 8'd0;
  logic [7:0] cur_id = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] len, input logic [11:0] da, input logic [11:0] sa,
                      input logic [2:0] st, input logic [1:0] ty);
    int n = 0;
    @(negedge clk);
    cmd_len = len; cmd_dram_addr = da; cmd_ld_addr = sa; cmd_str = st; cmd_sram_type = ty;
    cmd_vld = 1'b1;
    while (!cmd_rdy && n < 50) begin @(negedge clk); n++; end
    chk("push_accept", {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  // Waits (bounded) for an issue pulse and checks every command field
  task automatic check_issue(input string tag, input logic [11:0] da, input logic [11:0] sa,
                             input logic [7:0] al, input logic [2:0] st, input logic [1:0] ty,
                             input int lat);
    int n = 0;
    while (!ctrl_load_vld && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, {31'd0, ctrl_load_vld}, 32'd1);
    if (lat >= 0) chk({tag, "_lat"}, n, lat);
    chk({tag, "_id"},    {24'd0, ctrl_load_id}, {24'd0, exp_id});
    chk({tag, "_daddr"}, {20'd0, ctrl_load_dram_addr}, {20'd0, da});
    chk({tag, "_saddr"}, {20'd0, ctrl_load_ld_addr}, {20'd0, sa});
    chk({tag, "_arlen"}, {24'd0, ctrl_load_len}, {24'd0, al});
    chk({tag, "_size"},  {29'd0, ctrl_load_size}, 32'd2);
    chk({tag, "_str"},   {29'd0, ctrl_load_str}, {29'd0, st});
    chk({tag, "_type"},  {30'd0, ctrl_load_sram_type}, {30'd0, ty});
    cur_id = exp_id;
    exp_id = exp_id + 8'd1;
  endtask

  // Returns nb beats on cur_id; optional error beat and foreign-ID beat with rlast
  task automatic send_burst(input int nb, input int err_beat, input int foreign_at);
    for (int i = 0; i < nb; i++) begin
      if (i == foreign_at) begin
        @(negedge clk);
        ctrl_sram_rid = 8'h55; ctrl_sram_rresp = 2'b00; ctrl_sram_rlast = 1'b1;
        ctrl_sram_rvld = 1'b1;
      end
      @(negedge clk);
      ctrl_sram_rid   = cur_id;
      ctrl_sram_rresp = (i == err_beat) ? 2'b10 : 2'b00;
      ctrl_sram_rlast = (i == nb - 1);
      ctrl_sram_rvld  = 1'b1;
    end
    @(negedge clk);
    ctrl_sram_rvld = 1'b0; ctrl_sram_rlast = 1'b0; ctrl_sram_rresp = 2'b00;
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | ctrl_load_vld | sched_done | sched_err;
    end
    chk({tag, "_quiet"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bi;
    int done_at;
    int done_cnt;
    logic saw_vld;

    dv[0] = '{12'd40, 12'h100, 12'h010, 3'b101, 2'b10, 3};
    dv[1] = '{12'd17, 12'hFF0, 12'hFF8, 3'b011, 2'b01, 2};
    dv[2] = '{12'd1,  12'h004, 12'h000, 3'b000, 2'b11, 1};
    dv[3] = '{12'd16, 12'h020, 12'h100, 3'b111, 2'b00, 1};
    bv[0] = '{12'h100, 12'h010, 8'd15};
    bv[1] = '{12'h140, 12'h020, 8'd15};
    bv[2] = '{12'h180, 12'h030, 8'd7};
    bv[3] = '{12'hFF0, 12'hFF8, 8'd15};
    bv[4] = '{12'h030, 12'h008, 8'd0};
    bv[5] = '{12'h004, 12'h000, 8'd0};
    bv[6] = '{12'h020, 12'h100, 8'd15};

    rst_n = 1'b0; cmd_vld = 1'b0; cmd_len = '0; cmd_dram_addr = '0; cmd_ld_addr = '0;
    cmd_str = '0; cmd_sram_type = '0;
    ctrl_sram_rid = '0; ctrl_sram_rresp = '0; ctrl_sram_rlast = 1'b0; ctrl_sram_rvld = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy",  {31'd0, cmd_rdy}, 32'd0);
    chk("rst_vld",  {31'd0, ctrl_load_vld}, 32'd0);
    chk("rst_size", {29'd0, ctrl_load_size}, 32'd0);
    chk("rst_busy", {31'd0, sched_busy}, 32'd0);
    chk("rst_pulse", {30'd0, sched_done, sched_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, cmd_rdy}, 32'd1);

    // Table-driven descriptors, clean responses
    bi = 0;
    for (int d = 0; d < 4; d++) begin
      push(dv[d].len, dv[d].da, dv[d].sa, dv[d].st, dv[d].ty);
      for (int b = 0; b < dv[d].nb; b++) begin
        check_issue($sformatf("d%0d_b%0d", d, b), bv[bi].da, bv[bi].sa, bv[bi].al,
                    dv[d].st, dv[d].ty, (b == 0) ? 1 : 0);
        send_burst(int'(bv[bi].al) + 1, -1, (d == 0 && b == 1) ? 5 : -1);
        chk($sformatf("d%0d_b%0d_done", d, b), {31'd0, sched_done},
            (b == dv[d].nb - 1) ? 32'd1 : 32'd0);
        bi++;
      end
      @(negedge clk);
      chk($sformatf("d%0d_done_end", d), {31'd0, sched_done}, 32'd0);
      chk($sformatf("d%0d_busy_end", d), {31'd0, sched_busy}, 32'd0);
    end

    // Zero-length descriptor
    push(12'd0, 12'h7F0, 12'h070, 3'b001, 2'b01);
    done_at = -1; done_cnt = 0; saw_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_vld = saw_vld | ctrl_load_vld;
      if (sched_done) begin done_cnt++; if (done_at < 0) done_at = i; end
    end
    chk("len0_done_at", done_at, 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_no_issue", {31'd0, saw_vld}, 32'd0);
    chk("len0_busy", {31'd0, sched_busy}, 32'd0);

    // Error response on beat 3
    push(12'd8, 12'h200, 12'h040, 3'b010, 2'b01);
    check_issue("err", 12'h200, 12'h040, 8'd7, 3'b010, 2'b01, 1);
    send_burst(8, 3, -1);
`ifdef LOAD_SCHED_RETRY_EN
    chk("retry_no_err", {31'd0, sched_err}, 32'd0);
    check_issue("retry", 12'h200, 12'h040, 8'd7, 3'b010, 2'b01, 0);
    send_burst(8, -1, -1);
    chk("retry_done", {31'd0, sched_done}, 32'd1);
    @(negedge clk);
    // Exhaust retries: one issue plus three re-issues, all erroring
    push(12'd4, 12'h300, 12'h080, 3'b000, 2'b10);
    for (int r = 0; r < 4; r++) begin
      check_issue($sformatf("rx%0d", r), 12'h300, 12'h080, 8'd3, 3'b000, 2'b10,
                  (r == 0) ? 1 : 0);
      send_burst(4, 0, -1);
      chk($sformatf("rx%0d_err", r), {31'd0, sched_err}, (r == 3) ? 32'd1 : 32'd0);
    end
    quiet("rx", 8);
    chk("rx_busy", {31'd0, sched_busy}, 32'd0);
`else
    chk("err_pulse", {31'd0, sched_err}, 32'd1);
    chk("err_no_issue", {31'd0, ctrl_load_vld}, 32'd0);
    quiet("err", 10);
    chk("err_busy", {31'd0, sched_busy}, 32'd0);
`endif

    // Queue full: A in flight, B..E fill four entries, F refused
    push(12'd1, 12'h400, 12'h000, 3'b000, 2'b00);
    check_issue("qA", 12'h400, 12'h000, 8'd0, 3'b000, 2'b00, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_len = 12'd1; cmd_dram_addr = 12'h400 + 12'(k * 4); cmd_ld_addr = 12'(k);
      cmd_str = 3'b000; cmd_sram_type = 2'b00; cmd_vld = 1'b1;
      chk($sformatf("q_rdy%0d", k), {31'd0, cmd_rdy}, 32'd1);
    end
    @(negedge clk);
    cmd_dram_addr = 12'h414; cmd_ld_addr = 12'd5;
    chk("q_full_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("q_full_busy", {31'd0, sched_busy}, 32'd1);
    @(negedge clk);
    chk("q_full_rdy2", {31'd0, cmd_rdy}, 32'd0);
    cmd_vld = 1'b0;
    send_burst(1, -1, -1);
    chk("qA_done", {31'd0, sched_done}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check_issue($sformatf("q%0d", k), 12'h400 + 12'(k * 4), 12'(k), 8'd0, 3'b000, 2'b00, 1);
      send_burst(1, -1, -1);
      chk($sformatf("q%0d_done", k), {31'd0, sched_done}, 32'd1);
    end
    push(12'd1, 12'h414, 12'd5, 3'b000, 2'b00);
    check_issue("qF", 12'h414, 12'd5, 8'd0, 3'b000, 2'b00, 1);
    send_burst(1, -1, -1);
    chk("qF_done", {31'd0, sched_done}, 32'd1);
    @(negedge clk);

    // Reset mid-WAIT with a descriptor queued behind
    push(12'd8, 12'h500, 12'h050, 3'b000, 2'b00);
    check_issue("rw", 12'h500, 12'h050, 8'd7, 3'b000, 2'b00, 1);
    push(12'd4, 12'h600, 12'h060, 3'b000, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ctrl_sram_rid = cur_id; ctrl_sram_rresp = 2'b00; ctrl_sram_rlast = 1'b0;
      ctrl_sram_rvld = 1'b1;
    end
    @(negedge clk);
    ctrl_sram_rvld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_rst_vld",   {31'd0, ctrl_load_vld}, 32'd0);
    chk("rw_rst_busy",  {31'd0, sched_busy}, 32'd0);
    chk("rw_rst_pulse", {30'd0, sched_done, sched_err}, 32'd0);
    chk("rw_rst_rdy",   {31'd0, cmd_rdy}, 32'd0);
    rst_n = 1'b1;
    exp_id = 8'd0;
    @(negedge clk);
    chk("rw_busy_after", {31'd0, sched_busy}, 32'd0);
    send_burst(6, -1, -1);
    chk("rw_stale_pulse", {30'd0, sched_done, sched_err}, 32'd0);
    quiet("rw", 6);

    // ID counter restarts from 0 after reset
    push(12'd2, 12'h700, 12'h070, 3'b100, 2'b11);
    check_issue("post", 12'h700, 12'h070, 8'd1, 3'b100, 2'b11, 1);
    send_burst(2, -1, -1);
    chk("post_done", {31'd0, sched_done}, 32'd1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
